// File: rtl/effect_clipper_if.sv
// Sample-path bundle between the clipper, its input FIFO and the mixer.
// The master side is the clipper; the slave side is the FIFO/mixer pair.
interface effect_clipper_if #(
  parameter int data_width = 16
);
  logic [1:0]                   i_gain;
  logic                         i_fifo_empty;
  logic                         o_fifo_rd_en;
  logic signed [data_width-1:0] i_fifo_data;
  logic                         i_read_ready;
  logic                         i_read_done;
  logic                         o_data_valid;
  logic signed [data_width-1:0] o_data_dry;
  logic signed [data_width-1:0] o_data_clip;
  logic                         o_clip_active;

  modport master (
    input  i_gain, i_fifo_empty, i_fifo_data, i_read_ready, i_read_done,
    output o_fifo_rd_en, o_data_valid, o_data_dry, o_data_clip, o_clip_active
  );

  modport slave (
    output i_gain, i_fifo_empty, i_fifo_data, i_read_ready, i_read_done,
    input  o_fifo_rd_en, o_data_valid, o_data_dry, o_data_clip, o_clip_active
  );
endinterface

// File: rtl/effect_clipper.sv
// Clipping stage: pops one sample, applies x1..x8 pre-gain without wrap,
// hard-clips to +/-clip_level and presents dry/clipped pair to the mixer.
module effect_clipper #(
  parameter int data_width = 16,
  parameter int clip_level = 4096
) (
  input  logic             clk,
  input  logic             reset,
  effect_clipper_if.master bus
);
  localparam int gw = data_width + 3;
  localparam logic signed [gw-1:0] clip_pos = gw'(clip_level);
  localparam logic signed [gw-1:0] clip_neg = -clip_pos;

  typedef enum logic [2:0] {IDLE, READ, LATCH, GAIN, CLIP, WAIT, PRESENT} state_t;

  state_t                       state_q, state_d;
  logic signed [data_width-1:0] sample_q, sample_d;
  logic [1:0]                   gain_q, gain_d;
  logic signed [gw-1:0]         gained_q, gained_d;
  logic signed [data_width-1:0] dry_q, dry_d;
  logic signed [data_width-1:0] clip_q, clip_d;
  logic                         flag_q, flag_d;
  logic                         valid_q, valid_d;
  logic                         rd_en_q, rd_en_d;

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      sample_q <= '0;
      gain_q   <= '0;
      gained_q <= '0;
      dry_q    <= '0;
      clip_q   <= '0;
      flag_q   <= 1'b0;
      valid_q  <= 1'b0;
      rd_en_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sample_q <= sample_d;
      gain_q   <= gain_d;
      gained_q <= gained_d;
      dry_q    <= dry_d;
      clip_q   <= clip_d;
      flag_q   <= flag_d;
      valid_q  <= valid_d;
      rd_en_q  <= rd_en_d;
    end
  end

  // Next-state sequencing; CLIP jumps straight to PRESENT when the mixer is
  // already ready so valid appears 5 cycles after the pop decision
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!bus.i_fifo_empty) state_d = READ;
      READ:    state_d = LATCH;
      LATCH:   state_d = GAIN;
      GAIN:    state_d = CLIP;
      CLIP:    state_d = bus.i_read_ready ? PRESENT : WAIT;
      WAIT:    if (bus.i_read_ready) state_d = PRESENT;
      PRESENT: if (bus.i_read_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered strobes decoded from the next state, plus per-state datapath loads
  always_comb begin
    sample_d = sample_q;
    gain_d   = gain_q;
    gained_d = gained_q;
    dry_d    = dry_q;
    clip_d   = clip_q;
    flag_d   = flag_q;
    rd_en_d  = (state_d == READ);
    valid_d  = (state_d == PRESENT);
    case (state_q)
      LATCH: begin
        sample_d = bus.i_fifo_data;
        gain_d   = bus.i_gain;
      end
      GAIN: gained_d = {{3{sample_q[data_width-1]}}, sample_q} <<< gain_q;
      CLIP: begin
        dry_d = sample_q;
        if (gained_q > clip_pos) begin
          clip_d = clip_pos[data_width-1:0];
          flag_d = 1'b1;
        end else if (gained_q < clip_neg) begin
          clip_d = clip_neg[data_width-1:0];
          flag_d = 1'b1;
        end else begin
          clip_d = gained_q[data_width-1:0];
          flag_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign bus.o_fifo_rd_en  = rd_en_q;
  assign bus.o_data_valid  = valid_q;
  assign bus.o_data_dry    = dry_q;
  assign bus.o_data_clip   = clip_q;
  assign bus.o_clip_active = flag_q;
endmodule

// File: tb/tb_effect_clipper.sv
// Directed bench for effect_clipper with FIFO model and expected-result queue.
module tb_effect_clipper;
  localparam int cl = 4096;

  typedef struct {
    logic signed [15:0] dry;
    logic signed [15:0] clip;
    logic               flag;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  effect_clipper_if #(.data_width(16)) bus();
  effect_clipper #(.data_width(16), .clip_level(cl)) dut (
    .clk(clk), .reset(reset), .bus(bus.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: data appears the cycle after a pop strobe, pops ignored when empty
  logic signed [15:0] mem [64];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign bus.i_fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk) begin
    if (bus.o_fifo_rd_en === 1'b1 && wr_ptr != rd_ptr) begin
      bus.i_fifo_data <= mem[rd_ptr[5:0]];
      rd_ptr <= rd_ptr + 1;
    end
  end

  exp_t exp_q[$];
  exp_t held;
  int   rd_cyc[$];
  logic valid_prev = 1'b0;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Queue a sample in the FIFO and its expected result in the scoreboard
  task automatic push(input int s, input int g);
    exp_t   e;
    longint v;
    v = longint'(s) * longint'(1 << g);
    e.dry = 16'(s);
    if (v > cl) begin
      e.clip = 16'(cl); e.flag = 1'b1;
    end else if (v < -cl) begin
      e.clip = 16'(-cl); e.flag = 1'b1;
    end else begin
      e.clip = 16'(v); e.flag = 1'b0;
    end
    exp_q.push_back(e);
    bus.i_gain = g[1:0];
    mem[wr_ptr[5:0]] = 16'(s);
    wr_ptr++;
  endtask

  // Scoreboard compare on valid rise, hold/pop-exclusion checks while valid
  always @(negedge clk) begin
    if (bus.o_fifo_rd_en === 1'b1) rd_cyc.push_back(cyc);
    if (bus.o_data_valid === 1'b1) begin
      chk("no_rd_en_while_valid", bus.o_fifo_rd_en, 0);
      if (!valid_prev) begin
        tests++;
        assert (exp_q.size() > 0) else begin
          fails++;
          $error("FAIL sb_unexpected_valid: observed dry %0d expected no output",
                 bus.o_data_dry);
        end
        if (exp_q.size() > 0) begin
          held = exp_q.pop_front();
          chk("sb_dry", bus.o_data_dry, held.dry);
          chk("sb_clip", bus.o_data_clip, held.clip);
          chk("sb_flag", bus.o_clip_active, held.flag);
        end
      end else begin
        chk("hold_dry", bus.o_data_dry, held.dry);
        chk("hold_clip", bus.o_data_clip, held.clip);
        chk("hold_flag", bus.o_clip_active, held.flag);
      end
    end
    valid_prev = (bus.o_data_valid === 1'b1);
  end

  // Called at the negedge of the IDLE cycle that sees the FIFO non-empty
  task automatic run_sample(input string tag, input int gain_mid,
                            input int done_delay, output int n_valid);
    int n  = 0;
    bit seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) chk({tag, "_rd_en_c1"}, bus.o_fifo_rd_en, 1);
      if (n == 2) chk({tag, "_rd_en_c2"}, bus.o_fifo_rd_en, 0);
      if (n == 3) bus.i_gain = gain_mid[1:0];
      if (bus.o_data_valid === 1'b1) seen = 1;
    end
    n_valid = n;
    chk({tag, "_valid_seen"}, seen, 1);
    if (seen) begin
      repeat (done_delay) @(negedge clk);
      bus.i_read_done = 1'b1;
      @(negedge clk);
      bus.i_read_done = 1'b0;
      chk({tag, "_valid_fall"}, bus.o_data_valid, 0);
    end
  endtask

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: observed no finish expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    reset = 1'b1;
    bus.i_gain = 2'd0;
    bus.i_read_ready = 1'b0;
    bus.i_read_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", bus.o_data_valid, 0);
    chk("rst_rd_en", bus.o_fifo_rd_en, 0);
    chk("rst_dry", bus.o_data_dry, 0);
    chk("rst_clip", bus.o_data_clip, 0);
    chk("rst_flag", bus.o_clip_active, 0);
    reset = 1'b0;
    @(negedge clk);

    // Single in-range sample, done in the same cycle valid rises
    bus.i_read_ready = 1'b1;
    base = rd_cyc.size();
    push(1000, 0); run_sample("t1", 0, 0, n);
    chk("t1_valid_latency", n, 5);
    chk("t1_pop_count", rd_cyc.size() - base, 1);

    // Clipping both polarities at unity gain
    push(5000, 0);   run_sample("t2a", 0, 1, n);
    push(-20000, 0); run_sample("t2b", 0, 1, n);

    // Gain paths, most-negative input, gain change after latch
    push(2000, 2);   run_sample("g2", 2, 1, n);
    push(16000, 3);  run_sample("g3", 3, 1, n);
    push(-32768, 1); run_sample("g1neg", 1, 1, n);
    push(-32768, 3); run_sample("g3neg", 3, 1, n);
    push(300, 1);    run_sample("g1mid", 3, 1, n);
    chk("g1mid_flag_hold", bus.o_clip_active, 0);

    // Mixer not ready: waits, stray done ignored, then long hold in PRESENT
    bus.i_read_ready = 1'b0;
    base = rd_cyc.size();
    push(-1234, 2);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      bus.i_read_done = (i == 10);
      chk("wait_valid_low", bus.o_data_valid, 0);
    end
    bus.i_read_done = 1'b0;
    chk("wait_pop_count", rd_cyc.size() - base, 1);
    bus.i_read_ready = 1'b1;
    @(negedge clk);
    chk("ready_valid_next", bus.o_data_valid, 1);
    for (int i = 1; i <= 10; i++) begin
      if (i == 3) bus.i_read_ready = 1'b0;
      @(negedge clk);
      chk("present_valid_hold", bus.o_data_valid, 1);
    end
    bus.i_read_done = 1'b1;
    @(negedge clk);
    bus.i_read_done = 1'b0;
    bus.i_read_ready = 1'b1;
    chk("present_valid_fall", bus.o_data_valid, 0);
    chk("present_output_hold", bus.o_data_clip, -4096);

    // Three queued samples at full rate, clip boundaries
    base = rd_cyc.size();
    push(111, 0); push(-4097, 0); push(4096, 0);
    run_sample("b1", 0, 1, n);
    run_sample("b2", 0, 1, n);
    run_sample("b3", 0, 1, n);
    chk("burst_pop_count", rd_cyc.size() - base, 3);
    if (rd_cyc.size() - base == 3) begin
      chk("burst_period_12", rd_cyc[base+1] - rd_cyc[base], 7);
      chk("burst_period_23", rd_cyc[base+2] - rd_cyc[base+1], 7);
    end

    // Reset while presenting; second sample remains queued
    push(700, 1); push(-900, 1);
    n = 0;
    while (bus.o_data_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_valid_seen", bus.o_data_valid, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_valid", bus.o_data_valid, 0);
    chk("rst_mid_dry", bus.o_data_dry, 0);
    chk("rst_mid_clip", bus.o_data_clip, 0);
    chk("rst_mid_flag", bus.o_clip_active, 0);
    chk("rst_mid_rd_en", bus.o_fifo_rd_en, 0);
    reset = 1'b0;
    run_sample("after_rst", 1, 1, n);

    chk("total_pops", rd_cyc.size(), wr_ptr);
    chk("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
